// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN parameter-chain loader and its buffer.
package bnn_pkg;

    // Must match the tiny_bnn HIDDEN_UNITS/GLOBAL_OUTPUTS param chain length.
    localparam int unsigned CHAIN_BITS_DEFAULT = 192;
    localparam int unsigned ADDR_W_DEFAULT     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_VERIFY,
        ST_READY,
        ST_XLO,
        ST_XHI,
        ST_SAMPLE
    } state_e;

endpackage

// File: rtl/bnn_param_buf.sv
// Parameter image buffer: byte-wide host writes, single-bit combinational read.
module bnn_param_buf
    import bnn_pkg::*;
#(
    parameter int unsigned CHAIN_BITS = CHAIN_BITS_DEFAULT,
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned IDX_W      = $clog2(CHAIN_BITS)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_bit_o
);

    localparam int unsigned NBYTES = CHAIN_BITS / 8;

    logic [CHAIN_BITS-1:0] buf_q;

    // Addresses at or beyond NBYTES match no byte lane and are dropped.
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (wr_en_i && wr_addr_i == ADDR_W'(b)) begin
                buf_q[b*8 +: 8] <= wr_data_i;
            end
        end
    end

    assign rd_bit_o = buf_q[rd_idx_i];

endmodule

// File: rtl/bnn_chain_loader.sv
// Loads, verifies and then drives the tiny BNN core: param chain shift/readback
// followed by two-nibble inference sequencing.
module bnn_chain_loader
    import bnn_pkg::*;
#(
    parameter int unsigned CHAIN_BITS = CHAIN_BITS_DEFAULT,
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              start,
    input  logic              x_valid,
    input  logic [7:0]        x_data,
    output logic              net_setup,
    output logic              net_param,
    output logic              net_x_bank_hi,
    output logic [3:0]        net_x,
    input  logic [7:0]        net_out,
    output logic              busy,
    output logic              ready,
    output logic              err,
    output logic              y_valid,
    output logic [7:0]        y_data
);

    localparam int unsigned      CNT_W    = $clog2(CHAIN_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_BITS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       x_q, x_d;
    logic [7:0]       yd_q, yd_d;
    logic [3:0]       netx_q, netx_d;
    logic             smp_q, smp_d;
    logic             setup_q, setup_d;
    logic             param_q, param_d;
    logic             bank_q, bank_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             yv_q, yv_d;
    logic             start_ok, wr_ok, rd_bit;

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_READY);
    assign wr_ok    = wr_en && (state_q == ST_IDLE || state_q == ST_READY);

    // Read port follows cnt_d so net_param is registered alongside the count.
    bnn_param_buf #(
        .CHAIN_BITS(CHAIN_BITS),
        .ADDR_W    (ADDR_W),
        .IDX_W     (CNT_W)
    ) u_buf (
        .clk_i    (clk),
        .wr_en_i  (wr_ok),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .rd_idx_i (cnt_d),
        .rd_bit_o (rd_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        yd_d    = yd_q;
        smp_d   = smp_q;
        err_d   = err_q;
        ready_d = ready_q;
        yv_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    err_d   = 1'b0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_VERIFY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_VERIFY: begin
                // param_q still holds buf[cnt_q]; the buffer is frozen while busy.
                if (net_out[7] != param_q) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READY: begin
                if (start_ok) begin
                    err_d   = 1'b0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else if (x_valid) begin
                    x_d     = x_data;
                    state_d = ST_XLO;
                end
            end
            ST_XLO: state_d = ST_XHI;
            ST_XHI: begin
                smp_d   = 1'b0;
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (!smp_q) begin
                    yd_d  = net_out;
                    smp_d = 1'b1;
                end else begin
                    yv_d    = 1'b1;
                    smp_d   = 1'b0;
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        setup_d = (state_d == ST_IDLE) || (state_d == ST_SHIFT) || (state_d == ST_VERIFY);
        param_d = ((state_d == ST_SHIFT) || (state_d == ST_VERIFY)) && rd_bit;
        bank_d  = (state_d == ST_XHI);
        netx_d  = '0;
        if (state_d == ST_XLO) begin
            netx_d = x_d[3:0];
        end else if (state_d == ST_XHI) begin
            netx_d = x_d[7:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            yd_q    <= '0;
            netx_q  <= '0;
            smp_q   <= 1'b0;
            setup_q <= 1'b1;
            param_q <= 1'b0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            yd_q    <= yd_d;
            netx_q  <= netx_d;
            smp_q   <= smp_d;
            setup_q <= setup_d;
            param_q <= param_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            yv_q    <= yv_d;
        end
    end

    assign net_setup     = setup_q;
    assign net_param     = param_q;
    assign net_x_bank_hi = bank_q;
    assign net_x         = netx_q;
    assign busy          = (state_q == ST_SHIFT) || (state_q == ST_VERIFY);
    // A start seen in READY withdraws ready in the same cycle it is presented.
    assign ready         = ready_q && !(start && state_q == ST_READY);
    assign err           = err_q;
    assign y_valid       = yv_q;
    assign y_data        = yd_q;

endmodule
